serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Bit-serial adder sequencer. Drives one instance of the team's 1-bit cell Full_Adder
//   over WIDTH cycles to add two WIDTH-bit operands plus carry-in, LSB first.
//   Sits between a requester (start/done handshake) and the shared 1-bit adder.
//   Trades WIDTH cycles of latency for a single adder cell.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range 1..64.
// PORTS
//   clk    in   1      single clock, all state updates on rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; accepted only in IDLE or DONE
//   A      in   WIDTH  operand A, latched on accepted start
//   B      in   WIDTH  operand B, latched on accepted start
//   Cin    in   1      carry-in, latched on accepted start
//   busy   out  1      1 while state==RUN
//   done   out  1      one-cycle pulse, state==DONE; Sum/Cout valid
//   Sum    out  WIDTH  result A+B+Cin mod 2^WIDTH, held until next accepted start
//   Cout   out  1      carry out of bit WIDTH-1, held with Sum
// BEHAVIOUR
//   - Interface: one clock (clk); rst synchronous and active-high.
//   - Reset: state=IDLE, busy=0, done=0, Sum=0, Cout=0, bit counter=0, carry reg=0.
//     rst wins over every other input in the same cycle.
//   - FSM: IDLE -> RUN on start.
//     RUN -> RUN while cnt<WIDTH-1.
//     RUN -> DONE at edge processing bit WIDTH-1.
//     DONE -> RUN if start, else IDLE.
//   - Accepted start, sampled at edge k:
//     - latch A, B into shift regs; carry reg <= Cin; cnt <= 0.
//     - Sum, Cout are not cleared.
//   - RUN, each edge: feed A_sh[0], B_sh[0], carry to Full_Adder.
//     - Shift Sum_sh right with adder Sum into MSB.
//     - carry <= adder Cout; shift A_sh/B_sh right; cnt++.
//   - Edges k+1..k+WIDTH process bits 0..WIDTH-1.
//   - At edge k+WIDTH: Sum <= full shifted result; Cout <= final carry; state=DONE.
//   - done=1 for exactly the cycle after edge k+WIDTH; latency start->done = WIDTH+1 edges.
//   - start while RUN: ignored, no effect on operands or timing.
//   - start in DONE cycle: accepted (back-to-back); done still pulses that cycle.
//     - Sum/Cout keep the finished result until the next completion.
//   - A/B/Cin changes after acceptance: no effect (latched copies used).
//   - Counter width $clog2(WIDTH+1); no wrap: counter only counts 0..WIDTH-1.
//   - WIDTH=1: one RUN edge, then DONE; Sum=A^B^Cin, Cout=majority(A,B,Cin).
//   - rst mid-RUN: abort.
//     - Outputs return to reset values next cycle; no done pulse for the aborted op.
//   - Outputs registered; no combinational path from inputs to busy/done/Sum/Cout.
// TESTING (WIDTH=8 unless stated)
//   1. rst 2 cycles -> busy=0, done=0, Sum=0x00, Cout=0.
//      Then start A=0x00 B=0x00 Cin=0 -> done exactly 9 edges later, Sum=0x00 Cout=0.
//   2. A=0xFF B=0x01 Cin=0 -> Sum=0x00 Cout=1.
//      A=0xFF B=0xFF Cin=1 -> Sum=0xFF Cout=1.
//      A=0x5A B=0x33 Cin=0 -> Sum=0x8D Cout=0.
//   3. start A=0x10 B=0x20, then start A=0xFF B=0xFF at cnt=3 and toggle A/B during RUN
//      -> single done, Sum=0x30 Cout=0, busy high 8 cycles.
//   4. Assert rst at cnt=4 of A=0xAA B=0x55 -> next cycle busy=0, Sum=0, no done pulse.
//      New start then completes normally.
//   5. Back-to-back: start held high continuously with A=0x01 B=0x01, then A=0x80 B=0x80
//      -> done pulses every 9 cycles; results 0x02/0, then 0x00/1.
//   6. Random: 1000 random A/B/Cin vs {Cout,Sum}=A+B+Cin; repeat with WIDTH=1 (all 8 cases)
//      and WIDTH=16.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake and operand/result bundle for the bit-serial adder.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one 1-bit full-adder cell reused over WIDTH
// cycles, LSB first, behind a start/done handshake.
//
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | one operand bit pair added per edge
//   DONE   | result valid, done pulses; start here chains straight into RUN
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q;
  logic             carry_q;
  logic             busy_q, done_q, cout_q;
  logic [WIDTH-1:0] sum_q;

  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] a_sh_d, b_sh_d, sum_sh_d;

  // The shared 1-bit full-adder cell, fed from the operand LSBs and carry.
  always_comb begin
    fa_sum  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_cout = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  end

  // Shift-and-OR form keeps WIDTH=1 legal (no zero-width slices).
  always_comb begin
    a_sh_d   = a_sh_q >> 1;
    b_sh_d   = b_sh_q >> 1;
    sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            a_sh_q  <= bus.A;
            b_sh_q  <= bus.B;
            carry_q <= bus.Cin;
            cnt_q   <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_d;
          b_sh_q   <= b_sh_d;
          sum_sh_q <= sum_sh_d;
          carry_q  <= fa_cout;
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= sum_sh_d;
            cout_q  <= fa_cout;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed bench for serial_add_ctrl at WIDTH 8, 1 and 16,
// checked against plain integer addition.
module tb_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st [3];
  logic [63:0] av [3];
  logic [63:0] bv [3];
  logic        cv [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic [63:0] sum_v [3];
  logic        cout_v [3];
  logic [63:0] last_sum [3];
  logic        last_cout [3];
  int          wid [3] = '{8, 1, 16};
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8))  if8 ();
  serial_add_ctrl_if #(.WIDTH(1))  if1 ();
  serial_add_ctrl_if #(.WIDTH(16)) if16 ();

  serial_add_ctrl #(.WIDTH(8))  u_w8  (.clk(clk), .rst(rst), .bus(if8));
  serial_add_ctrl #(.WIDTH(1))  u_w1  (.clk(clk), .rst(rst), .bus(if1));
  serial_add_ctrl #(.WIDTH(16)) u_w16 (.clk(clk), .rst(rst), .bus(if16));

  assign if8.start  = st[0];  assign if8.A  = av[0][7:0];  assign if8.B  = bv[0][7:0];  assign if8.Cin  = cv[0];
  assign if1.start  = st[1];  assign if1.A  = av[1][0:0];  assign if1.B  = bv[1][0:0];  assign if1.Cin  = cv[1];
  assign if16.start = st[2];  assign if16.A = av[2][15:0]; assign if16.B = bv[2][15:0]; assign if16.Cin = cv[2];

  assign busy_v[0] = if8.busy;  assign done_v[0] = if8.done;  assign sum_v[0] = 64'(if8.Sum);  assign cout_v[0] = if8.Cout;
  assign busy_v[1] = if1.busy;  assign done_v[1] = if1.done;  assign sum_v[1] = 64'(if1.Sum);  assign cout_v[1] = if1.Cout;
  assign busy_v[2] = if16.busy; assign done_v[2] = if16.done; assign sum_v[2] = 64'(if16.Sum); assign cout_v[2] = if16.Cout;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] msk(int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // One operation: start pulse, operands scrambled after acceptance,
  // bounded wait for done, then latency/result/held-result checks.
  task automatic do_op(int u, logic [63:0] a_in, logic [63:0] b_in, logic c, string tag);
    int          w;
    int          n;
    logic [63:0] a, b;
    logic [64:0] r;
    w = wid[u];
    a = a_in & msk(w);
    b = b_in & msk(w);
    r = {1'b0, a} + {1'b0, b} + 65'(c);
    @(negedge clk);
    av[u] = a; bv[u] = b; cv[u] = c; st[u] = 1'b1;
    @(negedge clk);
    st[u] = 1'b0;
    n = 1;
    chk({tag, "_busy"}, 64'(busy_v[u]), 64'd1);
    chk({tag, "_held_sum"}, sum_v[u], last_sum[u]);
    av[u] = rnd64(); bv[u] = rnd64(); cv[u] = $urandom_range(1);
    while (!done_v[u] && n < w + 20) begin
      @(negedge clk);
      n++;
      av[u] = rnd64(); bv[u] = rnd64(); cv[u] = $urandom_range(1);
    end
    chk({tag, "_latency"}, 64'(n), 64'(w + 1));
    chk({tag, "_sum"}, sum_v[u], r[63:0] & msk(w));
    chk({tag, "_cout"}, 64'(cout_v[u]), 64'(r[w]));
    last_sum[u]  = r[63:0] & msk(w);
    last_cout[u] = r[w];
  endtask

  initial begin
    int bc, dc, d1, d2;
    for (int u = 0; u < 3; u++) begin
      st[u] = 1'b0; av[u] = '0; bv[u] = '0; cv[u] = 1'b0;
      last_sum[u] = '0; last_cout[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_busy", 64'(busy_v[u]), 64'd0);
      chk("rst_done", 64'(done_v[u]), 64'd0);
      chk("rst_sum",  sum_v[u], 64'd0);
      chk("rst_cout", 64'(cout_v[u]), 64'd0);
    end
    rst = 1'b0;

    do_op(0, 64'h00, 64'h00, 1'b0, "zero");
    do_op(0, 64'hFF, 64'h01, 1'b0, "ff_01");
    do_op(0, 64'hFF, 64'hFF, 1'b1, "ff_ff_c");
    do_op(0, 64'h5A, 64'h33, 1'b0, "5a_33");

    // start during RUN must be ignored; operands toggle freely.
    @(negedge clk);
    av[0] = 64'h10; bv[0] = 64'h20; cv[0] = 1'b0; st[0] = 1'b1;
    bc = 0; dc = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (busy_v[0]) bc++;
      if (done_v[0]) begin
        dc++;
        chk("ign_sum", sum_v[0], 64'h30);
        chk("ign_cout", 64'(cout_v[0]), 64'd0);
      end
      st[0] = (i == 3 || i == 4);
      av[0] = (i == 3) ? 64'hFF : rnd64();
      bv[0] = (i == 3) ? 64'hFF : rnd64();
    end
    st[0] = 1'b0;
    chk("ign_busy_cycles", 64'(bc), 64'd8);
    chk("ign_done_count", 64'(dc), 64'd1);
    last_sum[0] = 64'h30; last_cout[0] = 1'b0;

    // Synchronous reset in the middle of an operation aborts it.
    @(negedge clk);
    av[0] = 64'hAA; bv[0] = 64'h55; cv[0] = 1'b0; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy_v[0]), 64'd0);
    chk("abort_done", 64'(done_v[0]), 64'd0);
    chk("abort_sum", sum_v[0], 64'd0);
    chk("abort_cout", 64'(cout_v[0]), 64'd0);
    for (int u = 0; u < 3; u++) begin
      last_sum[u] = '0; last_cout[u] = 1'b0;
    end
    dc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) dc++;
    end
    chk("abort_no_done", 64'(dc), 64'd0);
    do_op(0, 64'hAA, 64'h55, 1'b1, "after_abort");

    // Back-to-back with start held high.
    @(negedge clk);
    av[0] = 64'h01; bv[0] = 64'h01; cv[0] = 1'b0; st[0] = 1'b1;
    d1 = 0; d2 = 0;
    for (int n = 1; n <= 40 && d2 == 0; n++) begin
      @(negedge clk);
      if (done_v[0]) begin
        if (d1 == 0) begin
          d1 = n;
          chk("b2b_sum1", sum_v[0], 64'h02);
          chk("b2b_cout1", 64'(cout_v[0]), 64'd0);
          av[0] = 64'h80; bv[0] = 64'h80;
        end else begin
          d2 = n;
          chk("b2b_sum2", sum_v[0], 64'h00);
          chk("b2b_cout2", 64'(cout_v[0]), 64'd1);
          st[0] = 1'b0;
        end
      end
    end
    st[0] = 1'b0;
    chk("b2b_first", 64'(d1), 64'd9);
    chk("b2b_period", 64'(d2 - d1), 64'd9);
    last_sum[0] = 64'h00; last_cout[0] = 1'b1;

    for (int i = 0; i < 1000; i++)
      do_op(0, rnd64(), rnd64(), 1'($urandom_range(1)), "rand8");
    for (int i = 0; i < 8; i++)
      do_op(1, 64'((i >> 2) & 1), 64'((i >> 1) & 1), 1'(i & 1), "w1");
    for (int i = 0; i < 300; i++)
      do_op(2, rnd64(), rnd64(), 1'($urandom_range(1)), "rand16");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
